// File: rtl/pmod_jstk_responder.sv
// rtl/pmod_jstk_responder.sv - SPI mode-0 slave emulating a PmodJSTK joystick (5-byte frame responder)
//
// Ports:
//   clk        system clock; SCLK must be at most clk/8
//   reset      synchronous active-low reset
//   x_pos      10-bit X value reported in bytes 0/1
//   y_pos      10-bit Y value reported in bytes 2/3
//   btn        {btn2, btn1, trigger} reported in byte 4
//   SS         slave select from master, active low (asynchronous pad)
//   SCLK       SPI clock from master, mode 0 (asynchronous pad, oversampled)
//   MOSI       master-out data (asynchronous pad)
//   MISO       slave-out data
//   MISO_EN    pad output enable for MISO
//   led        LED state from the last valid LED command
//   cmd_byte   last complete byte 0 received from the master
//   xfer_done  one-clk pulse when all 40 bits of a frame have been shifted
//   frame_err  one-clk pulse when SS deasserts before the frame completes
//   busy       high from frame start until SS returns high
`timescale 1ns/1ps
module pmod_jstk_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_EN,
    output logic [1:0] led,
    output logic [7:0] cmd_byte,
    output logic       xfer_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);
    localparam logic [5:0] CMD_LAST  = 6'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    // Tracks how far real pad samples have propagated through the synchronizer
    // since reset, so the idle level loaded at reset is never mistaken for a
    // genuine SS-high observation.
    logic [SYNC_STAGES-1:0] sync_valid;
    logic                   armed;
    logic                   ss_q;
    logic                   sclk_q;

    logic [38:0] tx;
    logic [6:0]  rx;
    logic [5:0]  cnt;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [39:0] image;
    logic [7:0]  rx_byte;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A fall only counts once SS has actually been seen high from the pad;
    // this keeps the block idle after reset when SS is already held low.
    assign ss_fall   = armed & ss_q & ~ss_s;
    assign ss_rise   = ~ss_q & ss_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    assign image = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, btn};
    assign rx_byte = {rx, mosi_s};

    always_ff @(posedge clk) begin
        if (!reset) begin
            ss_sync    <= '1;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            sync_valid <= '0;
            armed      <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
        end else begin
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
            if (sync_valid[SYNC_STAGES-1] && ss_s)
                armed <= 1'b1;
            ss_q       <= ss_s;
            sclk_q     <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            MISO      <= 1'b0;
            MISO_EN   <= 1'b0;
            led       <= 2'b00;
            cmd_byte  <= 8'h00;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            cnt       <= '0;
        end else begin
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    MISO_EN <= 1'b0;
                    busy    <= 1'b0;
                    MISO    <= 1'b0;
                    if (ss_fall) begin
                        // Snapshot the whole frame so input changes mid-frame are invisible.
                        tx      <= image[38:0];
                        MISO    <= image[39];
                        MISO_EN <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        rx      <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS rise has priority over any SCLK edge seen in the same clk.
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                        MISO_EN   <= 1'b0;
                        MISO      <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx  <= rx_byte[6:0];
                        cnt <= cnt + 6'd1;
                        if (cnt == CMD_LAST) begin
                            cmd_byte <= rx_byte;
                            if (rx_byte[7:2] == 6'b100000)
                                led <= rx_byte[1:0];
                        end
                        if (cnt == LAST_BIT) begin
                            xfer_done <= 1'b1;
                            MISO      <= 1'b0;
                            state     <= DONE;
                        end
                    end else if (sclk_fall) begin
                        MISO <= tx[38];
                        tx   <= {tx[37:0], 1'b0};
                    end
                end
                DONE: begin
                    MISO <= 1'b0;
                    if (ss_rise) begin
                        MISO_EN <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    MISO_EN <= 1'b0;
                    busy    <= 1'b0;
                    MISO    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
